// File: rtl/vdp_super_palette.sv
// ============================================================================
// vdp_super_palette
// 256-entry x 24-bit RGB palette for the super-resolution video path.
//
// Port A (video): PALETTE_ADDR2 is captured every clock and the R/G/B of that
// entry appears on the registered outputs after that edge. Reads are
// read-first against a port B write to the same entry.
//
// Port B (CPU / init): after reset a sequencer fills all 256 entries with a
// 3-3-2 colour cube (init_busy high). Afterwards the CPU loads an index
// (pal_index_wr), then streams R, G, B bytes (pal_data_wr) or reads them back
// (pal_data_rd). The index auto-increments after each B byte.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   PALETTE_ADDR2[7:0]         video palette index
//   PALETTE_DATA_{R,G,B}2_OUT  registered colour for the previous index
//   pal_index_wr               load cpu_index from cpu_data, phase -> R
//   pal_data_wr                write one channel byte from cpu_data
//   pal_data_rd                read one channel byte into cpu_rd_data
//   cpu_data[7:0]              CPU write data
//   cpu_rd_data[7:0]           CPU read data (one cycle after strobe edge)
//   init_busy                  high while the default fill runs
// ============================================================================
module vdp_super_palette (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] PALETTE_ADDR2,
    output logic [7:0] PALETTE_DATA_R2_OUT,
    output logic [7:0] PALETTE_DATA_G2_OUT,
    output logic [7:0] PALETTE_DATA_B2_OUT,
    input  logic       pal_index_wr,
    input  logic       pal_data_wr,
    input  logic       pal_data_rd,
    input  logic [7:0] cpu_data,
    output logic [7:0] cpu_rd_data,
    output logic       init_busy
);

    typedef enum logic {ST_INIT, ST_IDLE} state_t;
    typedef enum logic [1:0] {PH_R, PH_G, PH_B} phase_t;

    logic [23:0] mem [0:255];

    state_t      state, state_nxt;
    logic [7:0]  init_cnt;

    logic [7:0]  cpu_index;
    phase_t      phase;
    logic [7:0]  stg_r, stg_g;
    logic        rd_pend;
    phase_t      rd_sel;
    logic [23:0] rdata_b;

    logic        do_idx, do_wr, do_rd, commit;
    logic        ram_we;
    logic [7:0]  ram_waddr;
    logic [23:0] ram_wdata;

    // Default colour cube: each channel's top bits replicated to fill 8 bits
    // so that all-ones maps to 0xFF and all-zeros to 0x00.
    function automatic logic [23:0] cube_rgb(input logic [7:0] n);
        return {n[7:5], n[7:5], n[7:6],
                n[4:2], n[4:2], n[4:3],
                n[1:0], n[1:0], n[1:0], n[1:0]};
    endfunction

    function automatic phase_t next_phase(input phase_t p);
        case (p)
            PH_R:    return PH_G;
            PH_G:    return PH_B;
            default: return PH_R;
        endcase
    endfunction

    function automatic logic [7:0] pick_channel(input logic [23:0] rgb, input phase_t p);
        case (p)
            PH_R:    return rgb[23:16];
            PH_G:    return rgb[15:8];
            default: return rgb[7:0];
        endcase
    endfunction

    // ---------------- init sequencer ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_INIT;
            init_cnt <= 8'd0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT)
                init_cnt <= init_cnt + 8'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        init_busy = 1'b0;
        case (state)
            ST_INIT: begin
                init_busy = 1'b1;
                if (init_cnt == 8'd255)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Strobe priority: index load > data write > data read; all ignored in INIT.
    always_comb begin
        do_idx = !init_busy && pal_index_wr;
        do_wr  = !init_busy && !pal_index_wr && pal_data_wr;
        do_rd  = !init_busy && !pal_index_wr && !pal_data_wr && pal_data_rd;
        commit = do_wr && (phase == PH_B);
    end

    // ---------------- CPU index / phase / staging ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_index   <= 8'd0;
            phase       <= PH_R;
            stg_r       <= 8'd0;
            stg_g       <= 8'd0;
            rd_pend     <= 1'b0;
            rd_sel      <= PH_R;
            cpu_rd_data <= 8'd0;
        end else begin
            rd_pend <= do_rd;
            if (do_idx) begin
                cpu_index <= cpu_data;
                phase     <= PH_R;
            end else if (do_wr) begin
                case (phase)
                    PH_R:    stg_r <= cpu_data;
                    PH_G:    stg_g <= cpu_data;
                    default: cpu_index <= cpu_index + 8'd1;
                endcase
                phase <= next_phase(phase);
            end else if (do_rd) begin
                rd_sel <= phase;
                phase  <= next_phase(phase);
                if (phase == PH_B)
                    cpu_index <= cpu_index + 8'd1;
            end
            // rdata_b captured the pre-increment entry at the strobe edge.
            if (rd_pend)
                cpu_rd_data <= pick_channel(rdata_b, rd_sel);
        end
    end

    // ---------------- port B: write (init or CPU commit), continuous read ----------------
    always_comb begin
        ram_we    = init_busy || commit;
        ram_waddr = init_busy ? init_cnt : cpu_index;
        ram_wdata = init_busy ? cube_rgb(init_cnt) : {stg_r, stg_g, cpu_data};
    end

    always_ff @(posedge clk) begin
        if (ram_we)
            mem[ram_waddr] <= ram_wdata;
        rdata_b <= mem[cpu_index];
    end

    // ---------------- port A: video read, read-first ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PALETTE_DATA_R2_OUT <= 8'd0;
            PALETTE_DATA_G2_OUT <= 8'd0;
            PALETTE_DATA_B2_OUT <= 8'd0;
        end else begin
            {PALETTE_DATA_R2_OUT, PALETTE_DATA_G2_OUT, PALETTE_DATA_B2_OUT} <= mem[PALETTE_ADDR2];
        end
    end

endmodule

// File: tb/tb_vdp_super_palette.sv
module tb_vdp_super_palette;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] PALETTE_ADDR2 = 8'd0;
    logic [7:0] PALETTE_DATA_R2_OUT, PALETTE_DATA_G2_OUT, PALETTE_DATA_B2_OUT;
    logic       pal_index_wr = 1'b0;
    logic       pal_data_wr = 1'b0;
    logic       pal_data_rd = 1'b0;
    logic [7:0] cpu_data = 8'd0;
    logic [7:0] cpu_rd_data;
    logic       init_busy;

    vdp_super_palette dut (
        .clk                 (clk),
        .reset               (reset),
        .PALETTE_ADDR2       (PALETTE_ADDR2),
        .PALETTE_DATA_R2_OUT (PALETTE_DATA_R2_OUT),
        .PALETTE_DATA_G2_OUT (PALETTE_DATA_G2_OUT),
        .PALETTE_DATA_B2_OUT (PALETTE_DATA_B2_OUT),
        .pal_index_wr        (pal_index_wr),
        .pal_data_wr         (pal_data_wr),
        .pal_data_rd         (pal_data_rd),
        .cpu_data            (cpu_data),
        .cpu_rd_data         (cpu_rd_data),
        .init_busy           (init_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [23:0] m_mem [256];
    logic        m_def = 1'b0;   // model RAM contents known (after first fill)
    logic        m_busy = 1'b1;
    int          m_n = 0;
    logic [7:0]  m_idx = 8'd0;
    int          m_ph = 0;       // 0=R 1=G 2=B
    logic [7:0]  m_sr = 8'd0, m_sg = 8'd0;
    logic        m_rdp = 1'b0;
    logic [7:0]  m_rdv = 8'd0;
    logic [7:0]  m_rd = 8'd0;

    function automatic logic [23:0] cube(input int n);
        int r3, g3, b2;
        r3 = (n >> 5) & 7;
        g3 = (n >> 2) & 7;
        b2 = n & 3;
        return {8'((r3 << 5) | (r3 << 2) | (r3 >> 1)),
                8'((g3 << 5) | (g3 << 2) | (g3 >> 1)),
                8'(b2 * 85)};
    endfunction

    function automatic logic [23:0] vid();
        return {PALETTE_DATA_R2_OUT, PALETTE_DATA_G2_OUT, PALETTE_DATA_B2_OUT};
    endfunction

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, check after the edge.
    task automatic step(input logic [7:0] a, input logic iw, input logic dw,
                        input logic dr, input logic [7:0] d);
        logic [23:0] ev, w;
        logic        nvp;
        logic [7:0]  nv;
        PALETTE_ADDR2 = a;
        pal_index_wr  = iw;
        pal_data_wr   = dw;
        pal_data_rd   = dr;
        cpu_data      = d;
        ev  = m_mem[a];
        nvp = 1'b0;
        nv  = 8'd0;
        if (m_busy) begin
            m_mem[m_n] = cube(m_n);
            if (m_n == 255) m_busy = 1'b0;
            m_n = m_n + 1;
        end else if (iw) begin
            m_idx = d;
            m_ph  = 0;
        end else if (dw) begin
            if (m_ph == 0) m_sr = d;
            else if (m_ph == 1) m_sg = d;
            else begin
                m_mem[m_idx] = {m_sr, m_sg, d};
                m_idx = m_idx + 8'd1;
            end
            m_ph = (m_ph + 1) % 3;
        end else if (dr) begin
            w = m_mem[m_idx];
            if (m_ph == 0) nv = w[23:16];
            else if (m_ph == 1) nv = w[15:8];
            else nv = w[7:0];
            nvp = 1'b1;
            m_ph = m_ph + 1;
            if (m_ph == 3) begin
                m_ph  = 0;
                m_idx = m_idx + 8'd1;
            end
        end
        @(posedge clk);
        if (m_rdp) m_rd = m_rdv;
        m_rdp = nvp;
        m_rdv = nv;
        #1;
        pal_index_wr = 1'b0;
        pal_data_wr  = 1'b0;
        pal_data_rd  = 1'b0;
        check("init_busy", {23'd0, init_busy}, {23'd0, m_busy});
        check("cpu_rd_data", {16'd0, cpu_rd_data}, {16'd0, m_rd});
        if (m_def) check("video", vid(), ev);
    endtask

    task automatic idle(input logic [7:0] a);
        step(a, 1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        m_busy = 1'b1; m_n = 0; m_idx = 8'd0; m_ph = 0;
        m_sr = 8'd0; m_sg = 8'd0; m_rdp = 1'b0; m_rd = 8'd0;
        check("rst_video", vid(), 24'd0);
        check("rst_rd", {16'd0, cpu_rd_data}, 24'd0);
        check("rst_busy", {23'd0, init_busy}, 24'd1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic run_init(output int cnt);
        cnt = 0;
        while (init_busy === 1'b1 && cnt < 1000) begin
            cnt++;
            idle(8'($urandom));
        end
    endtask

    task automatic wr3(input logic [7:0] a, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        step(a, 1'b0, 1'b1, 1'b0, r);
        step(a, 1'b0, 1'b1, 1'b0, g);
        step(a, 1'b0, 1'b1, 1'b0, b);
    endtask

    initial begin
        int cnt, sel;
        logic [7:0] a;

        @(posedge clk);
        #1;
        do_reset();
        run_init(cnt);
        check("init_cycles", 24'(cnt), 24'd256);
        m_def = 1'b1;

        // Default cube corners
        idle(8'hFF); check("cube_ff", vid(), 24'hFFFFFF);
        idle(8'h00); check("cube_00", vid(), 24'h000000);
        idle(8'hE0); check("cube_e0", vid(), 24'hFF0000);
        idle(8'h1C); check("cube_1c", vid(), 24'h00FF00);
        idle(8'h03); check("cube_03", vid(), 24'h0000FF);

        // Basic write
        step(8'h00, 1'b1, 1'b0, 1'b0, 8'h10);
        wr3(8'h00, 8'h12, 8'h34, 8'h56);
        idle(8'h10); check("wr_10", vid(), 24'h123456);
        step(8'h00, 1'b0, 1'b0, 1'b1, 8'h00);
        idle(8'h00); check("rd_idx11", {16'd0, cpu_rd_data}, {16'd0, cube(8'h11) >> 16});

        // Index wrap
        step(8'h00, 1'b1, 1'b0, 1'b0, 8'hFF);
        wr3(8'h00, 8'hAA, 8'hBB, 8'hCC);
        wr3(8'h00, 8'h01, 8'h02, 8'h03);
        idle(8'hFF); check("wrap_ff", vid(), 24'hAABBCC);
        idle(8'h00); check("wrap_00", vid(), 24'h010203);

        // Partial sequence discarded by index load; simultaneous data dropped
        step(8'h00, 1'b1, 1'b0, 1'b0, 8'h50);
        step(8'h00, 1'b0, 1'b1, 1'b0, 8'h11);
        step(8'h00, 1'b0, 1'b1, 1'b0, 8'h22);
        step(8'h00, 1'b1, 1'b1, 1'b0, 8'h20);
        wr3(8'h00, 8'h77, 8'h88, 8'h99);
        idle(8'h20); check("discard_20", vid(), 24'h778899);
        idle(8'h50); check("discard_50", vid(), 24'h499200);

        // Collision: video holds 0x40 while the CPU commits to 0x40
        step(8'h40, 1'b1, 1'b0, 1'b0, 8'h40);
        step(8'h40, 1'b0, 1'b1, 1'b0, 8'hDE);
        step(8'h40, 1'b0, 1'b1, 1'b0, 8'hAD);
        step(8'h40, 1'b0, 1'b1, 1'b0, 8'hBE);
        check("coll_old", vid(), 24'h490000);
        idle(8'h40); check("coll_new", vid(), 24'hDEADBE);
        step(8'h40, 1'b1, 1'b0, 1'b0, 8'h40);
        step(8'h40, 1'b0, 1'b0, 1'b1, 8'h00);
        idle(8'h40); check("rb_r", {16'd0, cpu_rd_data}, 24'h0000DE);
        step(8'h40, 1'b0, 1'b0, 1'b1, 8'h00);
        idle(8'h40); check("rb_g", {16'd0, cpu_rd_data}, 24'h0000AD);
        step(8'h40, 1'b0, 1'b0, 1'b1, 8'h00);
        idle(8'h40); check("rb_b", {16'd0, cpu_rd_data}, 24'h0000BE);
        step(8'h40, 1'b0, 1'b0, 1'b1, 8'h00);
        idle(8'h40); check("rb_idx41", {16'd0, cpu_rd_data}, 24'h000049);

        // Randomized traffic, strobes separated by idle cycles
        for (int i = 0; i < 300; i++) begin
            a   = 8'($urandom);
            sel = int'($urandom_range(0, 9));
            if (sel == 0)
                step(a, 1'b1, 1'($urandom), 1'($urandom), 8'($urandom));
            else if (sel <= 5)
                step(a, 1'b0, 1'b1, 1'($urandom), 8'($urandom));
            else if (sel <= 8)
                step(a, 1'b0, 1'b0, 1'b1, 8'($urandom));
            else
                idle(a);
            idle(8'($urandom));
        end

        // Reset mid-sequence, then reset again mid-INIT; strobes during INIT ignored
        step(8'h00, 1'b0, 1'b1, 1'b0, 8'h99);
        do_reset();
        repeat (50) idle(8'($urandom));
        do_reset();
        repeat (10) idle(8'($urandom));
        step(8'h00, 1'b0, 1'b1, 1'b1, 8'h5A);
        step(8'h00, 1'b1, 1'b0, 1'b0, 8'h33);
        run_init(cnt);
        check("reinit_cycles", 24'(cnt + 12), 24'd256);
        idle(8'h00); check("reinit_00", vid(), 24'h000000);
        wr3(8'h00, 8'h01, 8'h02, 8'h03);
        idle(8'h00); check("post_init_00", vid(), 24'h010203);
        idle(8'hFF); check("post_init_ff", vid(), 24'hFFFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
